// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared direction, phase and timing definitions for the intersection scheduler
package traffic_pkg;

  // Approach indices, matching bit positions in the sensor and light vectors
  localparam int DIR_NS = 0;
  localparam int DIR_SN = 1;
  localparam int DIR_EW = 2;
  localparam int DIR_WE = 3;

  // Phase encoding; all four codes are used, so no illegal state exists
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_CLEAR  = 2'd3
  } phase_t;

  // Default timing, in clock cycles
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_T_PRIMARY  = 20;
  localparam int DEF_T_EXTENDED = 40;
  localparam int DEF_T_YELLOW   = 4;
  localparam int DEF_T_ALLRED   = 2;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin arbiter
// Searches from last+1 upward, wrapping 3 to 0; last itself is checked last.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  // First requester found after the previous winner takes the slot
  always_comb begin
    winner = last;
    valid  = 1'b0;
    idx    = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - intersection phase sequencer (IDLE/GREEN/YELLOW/CLEAR) with round-robin grant
// Optional build macro ADAPTIVE_EXT_EN: a congestion request on the served
// approach during a primary-length green lengthens that green once.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int T_PRIMARY  = DEF_T_PRIMARY,
  parameter int T_EXTENDED = DEF_T_EXTENDED,
  parameter int T_YELLOW   = DEF_T_YELLOW,
  parameter int T_ALLRED   = DEF_T_ALLRED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_s1,
  input  logic [3:0]       req_s5,
  output logic [3:0]       grant,
  output logic [3:0]       yellow,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] timer
);

  localparam logic [CNT_W-1:0] LD_PRI = CNT_W'(T_PRIMARY - 1);
  localparam logic [CNT_W-1:0] LD_EXT = CNT_W'(T_EXTENDED - 1);
  localparam logic [CNT_W-1:0] LD_YEL = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_CLR = CNT_W'(T_ALLRED - 1);

  phase_t           ph, ph_n;
  logic [CNT_W-1:0] timer_n;
  logic [3:0]       grant_n, yellow_n;
  logic [3:0]       pend, pend_n, cong, cong_n, clr;
  logic [1:0]       last, last_n;

  logic [3:0] p_eff, c_eff;
  logic [1:0] w_cong, w_all, w;
  logic       v_cong, v_all;

`ifdef ADAPTIVE_EXT_EN
  localparam logic [CNT_W:0] EXT_DELTA = (CNT_W + 1)'(T_EXTENDED - T_PRIMARY);
  logic           ext_mode, ext_mode_n, ext_done, ext_done_n;
  logic [CNT_W:0] ext_sum;
  assign ext_sum = {1'b0, timer} + EXT_DELTA - (CNT_W + 1)'(1);
`endif

  // Live requests count alongside the latched ones so IDLE reacts in one cycle
  assign p_eff = pend | req_s1 | req_s5;
  assign c_eff = cong | req_s5;
  assign w     = v_cong ? w_cong : w_all;
  assign phase = ph;

  rr_arbiter4 u_arb_cong (.req(c_eff & p_eff), .last(last), .winner(w_cong), .valid(v_cong));
  rr_arbiter4 u_arb_all  (.req(p_eff),         .last(last), .winner(w_all),  .valid(v_all));

  // Next-state, timer and light decode for the phase sequence
  always_comb begin
    ph_n     = ph;
    timer_n  = timer;
    grant_n  = grant;
    yellow_n = yellow;
    last_n   = last;
    clr      = 4'b0000;
`ifdef ADAPTIVE_EXT_EN
    ext_mode_n = ext_mode;
    ext_done_n = ext_done;
`endif
    case (ph)
      PH_IDLE: begin
        if (v_all) begin
          last_n  = w;
          grant_n = dir_onehot(w);
          clr     = dir_onehot(w);
          ph_n    = PH_GREEN;
          timer_n = c_eff[w] ? LD_EXT : LD_PRI;
`ifdef ADAPTIVE_EXT_EN
          ext_mode_n = c_eff[w];
          ext_done_n = 1'b0;
`endif
        end
      end
      PH_GREEN: begin
`ifdef ADAPTIVE_EXT_EN
        if (!ext_mode && !ext_done && req_s5[last] && (EXT_DELTA != '0)) begin
          timer_n    = ext_sum[CNT_W] ? '1 : ext_sum[CNT_W-1:0];
          ext_done_n = 1'b1;
        end else
`endif
        if (timer == '0) begin
          grant_n  = 4'b0000;
          yellow_n = dir_onehot(last);
          ph_n     = PH_YELLOW;
          timer_n  = LD_YEL;
        end else begin
          timer_n = timer - CNT_W'(1);
        end
      end
      PH_YELLOW: begin
        if (timer == '0) begin
          yellow_n = 4'b0000;
          ph_n     = PH_CLEAR;
          timer_n  = LD_CLR;
        end else begin
          timer_n = timer - CNT_W'(1);
        end
      end
      default: begin
        if (timer == '0) begin
          ph_n    = PH_IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer - CNT_W'(1);
        end
      end
    endcase
    // Entering green clears the winner's latches; clear beats a same-cycle set
    pend_n = (pend | req_s1 | req_s5) & ~clr;
    cong_n = (cong | req_s5) & ~clr;
  end

  // State register; reset leaves last at WE so NS has first priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= PH_IDLE;
      timer  <= '0;
      grant  <= 4'b0000;
      yellow <= 4'b0000;
      pend   <= 4'b0000;
      cong   <= 4'b0000;
      last   <= 2'd3;
`ifdef ADAPTIVE_EXT_EN
      ext_mode <= 1'b0;
      ext_done <= 1'b0;
`endif
    end else begin
      ph     <= ph_n;
      timer  <= timer_n;
      grant  <= grant_n;
      yellow <= yellow_n;
      pend   <= pend_n;
      cong   <= cong_n;
      last   <= last_n;
`ifdef ADAPTIVE_EXT_EN
      ext_mode <= ext_mode_n;
      ext_done <= ext_done_n;
`endif
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// tb/tb_phase_scheduler.sv - directed self-checking bench for phase_scheduler
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_s1 = 4'b0000;
  logic [3:0] req_s5 = 4'b0000;
  logic [3:0] grant, yellow;
  logic [1:0] phase;
  logic [7:0] timer;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  phase_scheduler dut (
    .clk(clk), .rst(rst), .req_s1(req_s1), .req_s5(req_s5),
    .grant(grant), .yellow(yellow), .phase(phase), .timer(timer)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_s1 = 4'b0000; req_s5 = 4'b0000;
    tick; tick;
    rst = 1'b0;
  endtask

  // Waits for the next green (bounded) and measures its length in cycles
  task automatic measure_green(output logic [3:0] g, output int start, output int len, output bit to);
    int w;
    w = 0; to = 1'b0; g = 4'b0000; start = 0; len = 0;
    while (grant === 4'b0000 && w < 300) begin
      tick; w++;
    end
    if (grant === 4'b0000) begin
      to = 1'b1;
    end else begin
      start = cyc;
      g = grant;
      while (grant === g && len < 300) begin
        len++; tick;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++; if (phase !== 2'd0)   begin bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
    total++; if (grant !== 4'h0)   begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (yellow !== 4'h0)  begin bad++; $display("FAIL reset_yellow: got %b want 0000", yellow); end
    total++; if (timer !== 8'd0)   begin bad++; $display("FAIL reset_timer: got %0d want 0", timer); end
    total++; if (dut.last !== 2'd3) begin bad++; $display("FAIL reset_last: got %0d want 3", dut.last); end
    do_reset;
  endtask

  task automatic test_single;
    int n;
    do_reset;
    req_s1 = 4'b0001; tick; req_s1 = 4'b0000;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", grant); end
    total++; if (phase !== 2'd1)    begin bad++; $display("FAIL single_phase_green: got %0d want 1", phase); end
    total++; if (timer !== 8'd19)   begin bad++; $display("FAIL single_timer_load: got %0d want 19", timer); end
    n = 0;
    while (grant === 4'b0001 && n < 200) begin n++; tick; end
    total++; if (n !== 20) begin bad++; $display("FAIL single_green_len: got %0d want 20", n); end
    total++; if (yellow !== 4'b0001 || grant !== 4'b0000 || phase !== 2'd2 || timer !== 8'd3) begin
      bad++; $display("FAIL single_yellow_entry: got y=%b g=%b ph=%0d t=%0d want y=0001 g=0000 ph=2 t=3", yellow, grant, phase, timer);
    end
    n = 0;
    while (phase === 2'd2 && n < 50) begin n++; tick; end
    total++; if (n !== 4) begin bad++; $display("FAIL single_yellow_len: got %0d want 4", n); end
    total++; if (phase !== 2'd3 || grant !== 4'h0 || yellow !== 4'h0 || timer !== 8'd1) begin
      bad++; $display("FAIL single_clear0: got ph=%0d g=%b y=%b t=%0d want ph=3 g=0 y=0 t=1", phase, grant, yellow, timer);
    end
    tick;
    total++; if (phase !== 2'd3 || grant !== 4'h0 || yellow !== 4'h0 || timer !== 8'd0) begin
      bad++; $display("FAIL single_clear1: got ph=%0d g=%b y=%b t=%0d want ph=3 g=0 y=0 t=0", phase, grant, yellow, timer);
    end
    tick;
    total++; if (phase !== 2'd0 || timer !== 8'd0) begin
      bad++; $display("FAIL single_idle_return: got ph=%0d t=%0d want ph=0 t=0", phase, timer);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] g, exp_g;
    int st, prev, len;
    bit to;
    do_reset;
    req_s1 = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      measure_green(g, st, len, to);
      total++; if (to || g !== exp_g) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", i, g, exp_g); end
      total++; if (len !== 20) begin bad++; $display("FAIL rr_len%0d: got %0d want 20", i, len); end
      if (i > 0) begin
        total++; if (st - prev !== 27) begin bad++; $display("FAIL rr_period%0d: got %0d want 27", i, st - prev); end
      end
      prev = st;
    end
    req_s1 = 4'b0000;
  endtask

  task automatic test_congestion;
    logic [3:0] g;
    int st, len;
    bit to;
    do_reset;
    req_s1 = 4'b0001; req_s5 = 4'b0100; tick;
    req_s1 = 4'b0000; req_s5 = 4'b0000;
    total++; if (grant !== 4'b0100 || timer !== 8'd39) begin
      bad++; $display("FAIL cong_first: got g=%b t=%0d want g=0100 t=39", grant, timer);
    end
    total++; if (dut.cong !== 4'b0000 || dut.pend !== 4'b0001) begin
      bad++; $display("FAIL cong_latches: got cong=%b pend=%b want cong=0000 pend=0001", dut.cong, dut.pend);
    end
    measure_green(g, st, len, to);
    total++; if (to || g !== 4'b0100 || len !== 40) begin bad++; $display("FAIL cong_ew_green: got g=%b len=%0d want g=0100 len=40", g, len); end
    measure_green(g, st, len, to);
    total++; if (to || g !== 4'b0001 || len !== 20) begin bad++; $display("FAIL cong_ns_green: got g=%b len=%0d want g=0001 len=20", g, len); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset;
    req_s1 = 4'b0001; tick; req_s1 = 4'b0000;
    tick; tick; tick;
    req_s1 = 4'b0010; tick; req_s1 = 4'b0000;
    for (int i = 0; i < 6; i++) tick;
    total++; if (dut.pend !== 4'b0010 || timer !== 8'd9) begin
      bad++; $display("FAIL mid_pre: got pend=%b t=%0d want pend=0010 t=9", dut.pend, timer);
    end
    rst = 1'b1;
    #1;
    total++; if (grant !== 4'h0 || phase !== 2'd0 || timer !== 8'd0 || dut.pend !== 4'h0) begin
      bad++; $display("FAIL mid_reset: got g=%b ph=%0d t=%0d pend=%b want all 0", grant, phase, timer, dut.pend);
    end
    tick;
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (phase !== 2'd0 || grant !== 4'h0) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL mid_idle_hold: got ph=%0d g=%b want idle held", phase, grant); end
  endtask

  task automatic test_adaptive;
    logic [3:0] g;
    int st, len, k, exp_len;
    bit to;
`ifdef ADAPTIVE_EXT_EN
    exp_len = 40;
`else
    exp_len = 20;
`endif
    do_reset;
    req_s1 = 4'b0001; tick; req_s1 = 4'b0000;
    k = 0;
    while (grant === 4'b0001 && k < 200) begin
      req_s5 = (k == 5 || k == 30) ? 4'b0001 : 4'b0000;
      tick; k++;
    end
    req_s5 = 4'b0000;
    total++; if (k !== exp_len) begin bad++; $display("FAIL adaptive_green_len: got %0d want %0d", k, exp_len); end
    measure_green(g, st, len, to);
    total++; if (to || g !== 4'b0001 || len !== 40) begin bad++; $display("FAIL adaptive_reserve: got g=%b len=%0d want g=0001 len=40", g, len); end
  endtask

  task automatic test_wrap;
    logic [3:0] g;
    int st, len;
    bit to;
    do_reset;
    req_s1 = 4'b1001; tick; req_s1 = 4'b0000;
    measure_green(g, st, len, to);
    total++; if (to || g !== 4'b0001) begin bad++; $display("FAIL wrap_ns: got %b want 0001", g); end
    measure_green(g, st, len, to);
    total++; if (to || g !== 4'b1000 || len !== 20) begin bad++; $display("FAIL wrap_we: got g=%b len=%0d want g=1000 len=20", g, len); end
  endtask

  initial begin
    tick;
    test_reset;
    test_single;
    test_round_robin;
    test_congestion;
    test_reset_mid;
    test_adaptive;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
